// File: rtl/seq_add_sub.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands are processed CHUNK bits per clock,
// with a carry register between slices and a start/busy/done handshake.
module seq_add_sub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             SnA,
    output logic [WIDTH-1:0] Y,
    output logic             CO,
    output logic             V,
    output logic             Z,
    output logic             BUSY,
    output logic             DONE
);

    localparam int NSLICE = WIDTH / CHUNK;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("seq_add_sub: WIDTH must be a multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             co_q, co_d;
    logic             v_q, v_d;
    logic             z_q, z_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CHUNK:0]   sum_s;

    // Operands shift right one slice per cycle, so the active slice always sits in the low bits
    // and the result fills in from the top; at the last slice the low bits hold the operand MSBs.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        co_d    = co_q;
        v_d     = v_q;
        z_d     = z_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        sum_s   = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};

        case (state_q)
            S_IDLE, S_FIN: begin
                if (START) begin
                    state_d = S_RUN;
                    a_d     = A;
                    b_d     = B ^ {WIDTH{SnA}};
                    carry_d = SnA;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_d                    = a_q >> CHUNK;
                b_d                    = b_q >> CHUNK;
                res_d                  = res_q >> CHUNK;
                res_d[WIDTH-1 -: CHUNK] = sum_s[CHUNK-1:0];
                carry_d                = sum_s[CHUNK];
                cnt_d                  = cnt_q + CW'(1);
                if (cnt_q == CW'(NSLICE - 1)) begin
                    state_d = S_FIN;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    y_d     = res_d;
                    co_d    = sum_s[CHUNK];
                    v_d     = (a_q[CHUNK-1] == b_q[CHUNK-1]) && (res_d[WIDTH-1] != a_q[CHUNK-1]);
                    z_d     = (res_d == '0);
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and output registers; reset abandons any in-flight operation.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            y_q     <= '0;
            co_q    <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            co_q    <= co_d;
            v_q     <= v_d;
            z_q     <= z_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Y    = y_q;
    assign CO   = co_q;
    assign V    = v_q;
    assign Z    = z_q;
    assign BUSY = busy_q;
    assign DONE = done_q;

endmodule

// File: tb/tb_seq_add_sub.sv
// Bench for seq_add_sub (WIDTH=32, CHUNK=8): directed vectors with literal expectations
// plus a per-cycle comparison against an arithmetic model of the handshake and results.
module tb_seq_add_sub;

    localparam int WIDTH  = 32;
    localparam int CHUNK  = 8;
    localparam int NSLICE = WIDTH / CHUNK;

    logic             CLK;
    logic             RST_N;
    logic             START;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             SnA;
    logic [WIDTH-1:0] Y;
    logic             CO;
    logic             V;
    logic             Z;
    logic             BUSY;
    logic             DONE;

    int total;
    int bad;

    seq_add_sub #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .START(START),
        .A    (A),
        .B    (B),
        .SnA  (SnA),
        .Y    (Y),
        .CO   (CO),
        .V    (V),
        .Z    (Z),
        .BUSY (BUSY),
        .DONE (DONE)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: unsigned compare for borrow, signed integer range for overflow.
    function automatic void model_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                                     output logic [31:0] y, output logic co, output logic v,
                                     output logic z);
        longint    sr;
        logic [32:0] wide;
        if (s) begin
            y  = a - b;
            co = (a >= b);
            sr = longint'($signed(a)) - longint'($signed(b));
        end else begin
            wide = {1'b0, a} + {1'b0, b};
            y    = wide[31:0];
            co   = wide[32];
            sr   = longint'($signed(a)) + longint'($signed(b));
        end
        v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        z = (y == 32'd0);
    endfunction

    // Model state: one operation in flight at most, retiring NSLICE edges after acceptance.
    logic        pend_v;
    int          pend_cnt;
    logic [31:0] pend_y;
    logic        pend_co, pend_vf, pend_z;
    logic [31:0] exp_y;
    logic        exp_co, exp_v, exp_z, exp_done;

    initial begin
        pend_v   = 1'b0;
        pend_cnt = 0;
        exp_y    = 32'd0;
        exp_co   = 1'b0;
        exp_v    = 1'b0;
        exp_z    = 1'b0;
        exp_done = 1'b0;
        forever begin
            @(posedge CLK);
            if (!RST_N) begin
                pend_v   = 1'b0;
                exp_y    = 32'd0;
                exp_co   = 1'b0;
                exp_v    = 1'b0;
                exp_z    = 1'b0;
                exp_done = 1'b0;
            end else begin
                exp_done = 1'b0;
                if (pend_v) begin
                    pend_cnt++;
                    if (pend_cnt == NSLICE) begin
                        exp_y    = pend_y;
                        exp_co   = pend_co;
                        exp_v    = pend_vf;
                        exp_z    = pend_z;
                        exp_done = 1'b1;
                        pend_v   = 1'b0;
                    end
                end else if (START) begin
                    pend_v   = 1'b1;
                    pend_cnt = 0;
                    model_op(A, B, SnA, pend_y, pend_co, pend_vf, pend_z);
                end
            end
            #2;
            check("busy", {63'd0, BUSY}, {63'd0, pend_v});
            check("done", {63'd0, DONE}, {63'd0, exp_done});
            check("y", {32'd0, Y}, {32'd0, exp_y});
            check("co", {63'd0, CO}, {63'd0, exp_co});
            check("v", {63'd0, V}, {63'd0, exp_v});
            check("z", {63'd0, Z}, {63'd0, exp_z});
        end
    end

    // Issue one operation starting at the next falling edge and check literal results.
    // glitch_at > 0 raises START with different operands that many cycles after acceptance.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input int glitch_at, input logic [31:0] ey, input logic eco,
                          input logic ev, input logic ez);
        int n;
        @(negedge CLK);
        A     = a;
        B     = b;
        SnA   = s;
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        A     = 32'hDEAD_BEEF;
        n     = 0;
        do begin
            @(posedge CLK);
            #1;
            n++;
            if (glitch_at > 0 && n == glitch_at) begin
                START = 1'b1;
                A     = 32'd1;
                B     = 32'd1;
                SnA   = 1'b0;
            end else begin
                START = 1'b0;
            end
        end while (!DONE && n < 20);
        check("latency", 64'(n), 64'(NSLICE));
        check("op_y", {32'd0, Y}, {32'd0, ey});
        check("op_co", {63'd0, CO}, {63'd0, eco});
        check("op_v", {63'd0, V}, {63'd0, ev});
        check("op_z", {63'd0, Z}, {63'd0, ez});
    endtask

    initial begin
        total = 0;
        bad   = 0;
        RST_N = 1'b0;
        START = 1'b0;
        A     = 32'd0;
        B     = 32'd0;
        SnA   = 1'b0;
        repeat (2) @(negedge CLK);
        check("rst_busy", {63'd0, BUSY}, 64'd0);
        check("rst_done", {63'd0, DONE}, 64'd0);
        check("rst_y", {32'd0, Y}, 64'd0);
        RST_N = 1'b1;

        run_op(32'd5, 32'd2, 1'b0, 0, 32'd7, 1'b0, 1'b0, 1'b0);
        run_op(32'd5, 32'd2, 1'b1, 0, 32'd3, 1'b1, 1'b0, 1'b0);
        run_op(32'd2, 32'd5, 1'b1, 0, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0);
        run_op(32'd0, 32'd1, 1'b1, 0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        run_op(32'h7FFF_FFFF, 32'd5, 1'b0, 0, 32'h8000_0004, 1'b0, 1'b1, 1'b0);
        run_op(32'd5, 32'd5, 1'b1, 0, 32'd0, 1'b1, 1'b0, 1'b1);
        run_op(32'h0000_00FF, 32'h0000_FFFF, 1'b1, 0, 32'hFFFF_0100, 1'b0, 1'b0, 1'b0);
        run_op(32'h8000_0000, 32'd1, 1'b1, 0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 0, 32'd0, 1'b1, 1'b0, 1'b1);
        run_op(32'd7, 32'd0, 1'b1, 0, 32'd7, 1'b1, 1'b0, 1'b0);
        // START while busy is ignored; next call starts inside the DONE cycle
        run_op(32'd5, 32'd2, 1'b0, 2, 32'd7, 1'b0, 1'b0, 1'b0);
        run_op(32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 0, 32'h2143_6587, 1'b0, 1'b0, 1'b0);

        // Reset two cycles into a run: outputs clear at once, no completion follows
        @(negedge CLK);
        A     = 32'd9;
        B     = 32'd3;
        SnA   = 1'b0;
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b0;
        #1;
        check("abort_busy", {63'd0, BUSY}, 64'd0);
        check("abort_y", {32'd0, Y}, 64'd0);
        check("abort_done", {63'd0, DONE}, 64'd0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge CLK);
            #1;
            check("abort_nodone", {63'd0, DONE}, 64'd0);
        end
        run_op(32'd9, 32'd3, 1'b1, 0, 32'd6, 1'b1, 1'b0, 1'b0);

        // Random traffic, checked every cycle by the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            START = 1'($urandom_range(0, 1));
            A     = $urandom;
            B     = ($urandom_range(0, 7) == 0) ? A : $urandom;
            SnA   = 1'($urandom_range(0, 1));
        end
        @(negedge CLK);
        START = 1'b0;
        repeat (NSLICE + 3) @(negedge CLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
